// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e : binary-encoded fetch FSM states (IDLE/ADDR/READ/HOLD)
//   - DEF_ADDR_W    : default program memory address width
//   - DEF_DATA_W    : default instruction/memory word width
//   - RESET_PC      : program counter value after reset
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_READ = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W = 32'd4;
  localparam int unsigned DEF_DATA_W = 32'd16;
  localparam int unsigned RESET_PC   = 32'd0;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Program counter register with load and increment. Load has priority over
// increment; the increment is ADDR_W bits wide and the carry is discarded, so
// the count wraps modulo 2**ADDR_W.
// Ports:
//   clk      in  system clock, rising edge
//   clr      in  asynchronous active-high reset (count -> RESET_PC)
//   inc      in  advance count by one
//   load     in  replace count with load_val
//   load_val in  value to load
//   count    out current count
// -----------------------------------------------------------------------------
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  logic [ADDR_W-1:0] count_d;
  logic [ADDR_W-1:0] count_q;

  // Next count: load beats increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + ADDR_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= ADDR_W'(RESET_PC);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of the program memory. Owns the PC, drives the memory
// address/enable, captures the returned word into an instruction register and
// offers it downstream with a valid/ready handshake. Honours jump redirects
// and halt requests from execute.
// Ports:
//   clk         in  system clock, rising edge
//   clr         in  asynchronous active-high reset
//   run         in  start fetching (sampled in IDLE only)
//   halt        in  stop after the currently offered instruction is accepted
//   jump_en     in  redirect request pulse
//   jump_addr   in  redirect target
//   mem_address out address to program memory (= PC)
//   mem_enable  out program memory read enable (ADDR and READ states)
//   mem_data    in  word from program memory
//   instr       out instruction register
//   instr_valid out instr holds an unconsumed instruction
//   instr_ready in  downstream accepts instr this cycle
//   pc          out current PC (next address to fetch)
//   busy        out FSM not in IDLE
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] instr_d;
  logic              instr_valid_q;
  logic              instr_valid_d;
  logic              halt_pend_q;
  logic              halt_pend_d;
  logic              jump_pend_q;
  logic              jump_pend_d;
  logic [ADDR_W-1:0] jump_tgt_q;
  logic [ADDR_W-1:0] jump_tgt_d;

  logic              enter_addr_s;
  logic              pc_inc_s;
  logic              pc_load_s;
  logic [ADDR_W-1:0] pc_load_val_s;
  logic [ADDR_W-1:0] pc_s;

  // Next-state logic; enter_addr_s flags every edge that lands in ADDR,
  // which is where a pending redirect gets applied.
  always_comb begin
    state_d      = state_q;
    enter_addr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // halt wins over run in IDLE
        if (run && !halt) begin
          state_d      = ST_ADDR;
          enter_addr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: state_d = ST_READ;
      ST_READ: state_d = ST_HOLD;
      ST_HOLD: begin
        if (instr_ready) begin
          if (halt_pend_q || halt) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_ADDR;
            enter_addr_s = 1'b1;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction register, valid flag and pending halt/jump bookkeeping.
  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halt_pend_d   = halt_pend_q;
    jump_pend_d   = jump_pend_q;
    jump_tgt_d    = jump_tgt_q;

    // mem_data is only meaningful (driven) during READ
    if (state_q == ST_READ) begin
      instr_d       = mem_data;
      instr_valid_d = 1'b1;
    end else if ((state_q == ST_HOLD) && instr_ready) begin
      instr_valid_d = 1'b0;
    end else begin
      instr_valid_d = instr_valid_q;
    end

    case (state_q)
      ST_IDLE: halt_pend_d = 1'b0;
      ST_ADDR,
      ST_READ: begin
        if (halt) begin
          halt_pend_d = 1'b1;
        end else begin
          halt_pend_d = halt_pend_q;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          halt_pend_d = 1'b0;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end else begin
          halt_pend_d = halt_pend_q;
        end
      end
      default: halt_pend_d = 1'b0;
    endcase

    // A redirect is consumed on entry to ADDR (a same-edge pulse is consumed
    // directly via pc_load_val_s); otherwise the latest pulse is remembered.
    if (enter_addr_s) begin
      jump_pend_d = 1'b0;
    end else if (jump_en) begin
      jump_pend_d = 1'b1;
      jump_tgt_d  = jump_addr;
    end else begin
      jump_pend_d = jump_pend_q;
    end
  end

  assign pc_inc_s      = (state_q == ST_READ);
  assign pc_load_s     = enter_addr_s && (jump_en || jump_pend_q);
  assign pc_load_val_s = jump_en ? jump_addr : jump_tgt_q;

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .clr      (clr),
    .inc      (pc_inc_s),
    .load     (pc_load_s),
    .load_val (pc_load_val_s),
    .count    (pc_s)
  );

  // State, instruction and pending-flag registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
      jump_pend_q   <= 1'b0;
      jump_tgt_q    <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halt_pend_q   <= halt_pend_d;
      jump_pend_q   <= jump_pend_d;
      jump_tgt_q    <= jump_tgt_d;
    end
  end

  assign mem_enable  = (state_q == ST_ADDR) || (state_q == ST_READ);
  assign busy        = (state_q != ST_IDLE);
  assign mem_address = pc_s;
  assign pc          = pc_s;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit with a small program memory model.
// When mem_enable is low the memory model drives a recognisable idle pattern
// (16'hDEAD) so that sampling outside READ shows up in instr.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        clr;
  logic        run;
  logic        halt;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic [3:0]  mem_address;
  logic        mem_enable;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  pc;
  logic        busy;

  logic [15:0] mem [16];

  int n_cmp;
  int n_mis;

  instruction_fetch_unit #(
    .ADDR_W (4),
    .DATA_W (16)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .halt        (halt),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .mem_address (mem_address),
    .mem_enable  (mem_enable),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy)
  );

  assign mem_data = mem_enable ? mem[mem_address] : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hE000 | 16'(i);
    mem[0] = 16'h1A2B;
    mem[1] = 16'h3C4D;

    clr = 1'b1; run = 1'b0; halt = 1'b0; jump_en = 1'b0;
    jump_addr = 4'h0; instr_ready = 1'b1;

    // reset state
    tick(); tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_men", 32'(mem_enable), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_maddr", 32'(mem_address), 32'h0);
    clr = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // first two fetches with ready held high
    run = 1'b1;
    tick();                                   // cycle 1: ADDR
    run = 1'b0;
    check("c1_busy", 32'(busy), 32'h1);
    check("c1_men", 32'(mem_enable), 32'h1);
    check("c1_maddr", 32'(mem_address), 32'h0);
    tick();                                   // cycle 2: READ
    check("c2_men", 32'(mem_enable), 32'h1);
    check("c2_valid", 32'(instr_valid), 32'h0);
    tick();                                   // cycle 3: HOLD
    check("c3_instr", 32'(instr), 32'h1A2B);
    check("c3_valid", 32'(instr_valid), 32'h1);
    check("c3_pc", 32'(pc), 32'h1);
    check("c3_men", 32'(mem_enable), 32'h0);
    tick();                                   // cycle 4: ADDR
    check("c4_valid", 32'(instr_valid), 32'h0);
    check("c4_maddr", 32'(mem_address), 32'h1);
    check("c4_men", 32'(mem_enable), 32'h1);
    tick();                                   // cycle 5: READ
    tick();                                   // cycle 6: HOLD
    check("c6_instr", 32'(instr), 32'h3C4D);
    check("c6_valid", 32'(instr_valid), 32'h1);
    check("c6_pc", 32'(pc), 32'h2);

    // backpressure for 5 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_instr", 32'(instr), 32'h3C4D);
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_men", 32'(mem_enable), 32'h0);
    end
    instr_ready = 1'b1;
    tick();                                   // ADDR
    check("bp_rel_men", 32'(mem_enable), 32'h1);
    check("bp_rel_maddr", 32'(mem_address), 32'h2);
    check("bp_rel_valid", 32'(instr_valid), 32'h0);
    tick(); tick();                           // READ, HOLD
    check("f2_instr", 32'(instr), 32'hE002);
    check("f2_pc", 32'(pc), 32'h3);

    // jump to 15 during HOLD, then wrap to 0
    instr_ready = 1'b0;
    jump_en = 1'b1; jump_addr = 4'hF;
    tick();                                   // still HOLD, jump pending
    jump_en = 1'b0; jump_addr = 4'h0;
    check("jh_pc_unchanged", 32'(pc), 32'h3);
    instr_ready = 1'b1;
    tick();                                   // ADDR
    check("jh_maddr", 32'(mem_address), 32'hF);
    tick(); tick();                           // READ, HOLD
    check("wrap_instr", 32'(instr), 32'hE00F);
    check("wrap_pc", 32'(pc), 32'h0);
    tick();                                   // ADDR
    check("wrap_maddr", 32'(mem_address), 32'h0);

    // jump pulse in READ: current instr still delivered, pc still increments
    tick();                                   // READ
    jump_en = 1'b1; jump_addr = 4'h8;
    tick();                                   // HOLD
    jump_en = 1'b0; jump_addr = 4'h0;
    check("jr_instr", 32'(instr), 32'h1A2B);
    check("jr_pc", 32'(pc), 32'h1);
    tick();                                   // ADDR
    check("jr_maddr", 32'(mem_address), 32'h8);
    tick(); tick();                           // READ, HOLD
    check("jr_instr2", 32'(instr), 32'hE008);
    check("jr_pc2", 32'(pc), 32'h9);

    // halt asserted in ADDR
    tick();                                   // ADDR
    check("ha_maddr", 32'(mem_address), 32'h9);
    halt = 1'b1;
    tick();                                   // READ
    halt = 1'b0;
    tick();                                   // HOLD
    check("ha_instr", 32'(instr), 32'hE009);
    check("ha_valid", 32'(instr_valid), 32'h1);
    tick();                                   // IDLE after handshake
    check("ha_busy", 32'(busy), 32'h0);
    check("ha_men", 32'(mem_enable), 32'h0);
    check("ha_valid0", 32'(instr_valid), 32'h0);
    check("ha_pc", 32'(pc), 32'hA);
    tick();
    check("ha_men_idle", 32'(mem_enable), 32'h0);

    // run + halt together stays IDLE
    run = 1'b1; halt = 1'b1;
    tick();
    run = 1'b0; halt = 1'b0;
    check("rh_busy", 32'(busy), 32'h0);

    // halt alone in IDLE is dropped
    halt = 1'b1;
    tick();
    halt = 1'b0; run = 1'b1;
    tick();                                   // ADDR
    run = 1'b0;
    check("hi_busy", 32'(busy), 32'h1);
    check("hi_maddr", 32'(mem_address), 32'hA);
    tick();                                   // READ
    check("hi_read_men", 32'(mem_enable), 32'h1);

    // asynchronous clear mid-READ
    #1 clr = 1'b1;
    #1;
    check("ac_instr", 32'(instr), 32'h0);
    check("ac_valid", 32'(instr_valid), 32'h0);
    check("ac_pc", 32'(pc), 32'h0);
    check("ac_men", 32'(mem_enable), 32'h0);
    check("ac_busy", 32'(busy), 32'h0);
    tick();
    clr = 1'b0;
    tick();
    check("ac_idle_busy", 32'(busy), 32'h0);
    run = 1'b1;
    tick();                                   // ADDR
    run = 1'b0;
    check("rs_maddr", 32'(mem_address), 32'h0);
    tick(); tick();                           // READ, HOLD
    check("rs_instr", 32'(instr), 32'h1A2B);
    check("rs_pc", 32'(pc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
